// File: rtl/sdram_ctrl_cmd.sv
`default_nettype none
// ============================================================================
// Module  : sdram_ctrl_cmd
// Brief   : SDRAM command engine - power-up init, periodic auto-refresh and
//           single-word auto-precharge accesses on a registered 32-bit bus.
//           Optional macro SDRAM_CTRL_DQ_INREG_EN adds a DQ input register
//           (read capture and finish move one cycle later).
//           The refresh status output is named 'refresh' (ref is reserved).
// Rev     : 1.0  initial release
// ============================================================================
module sdram_ctrl_cmd #(
  parameter int T_INIT       = 20000,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int T_RCD        = 2,
  parameter int T_WR         = 2,
  parameter int CAS_LAT      = 2,
  parameter int REF_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic        we,
  input  logic [1:0]  ba,
  input  logic [12:0] row_addr,
  input  logic [8:0]  col_addr,
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  output logic [31:0] rd_data,
  output logic        finish,
  output logic        busy,
  output logic        refresh,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [3:0]  sdram_dqm,
  output logic [31:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  input  logic [31:0] sdram_dq_i
);

  localparam logic [3:0] c_cmd_nop   = 4'b0111;
  localparam logic [3:0] c_cmd_act   = 4'b0011;
  localparam logic [3:0] c_cmd_read  = 4'b0101;
  localparam logic [3:0] c_cmd_write = 4'b0100;
  localparam logic [3:0] c_cmd_pre   = 4'b0010;
  localparam logic [3:0] c_cmd_ref   = 4'b0001;
  localparam logic [3:0] c_cmd_mrs   = 4'b0000;

  localparam logic [2:0]  c_cl         = 3'(CAS_LAT);
  localparam logic [12:0] c_mode       = {6'b000000, c_cl, 4'b0000};
  localparam logic [15:0] c_t_init     = 16'(T_INIT);
  localparam logic [15:0] c_t_rp_m1    = 16'(T_RP - 1);
  localparam logic [15:0] c_t_rfc_m1   = 16'(T_RFC - 1);
  localparam logic [15:0] c_t_rfc_m2   = 16'(T_RFC - 2);
  localparam logic [15:0] c_t_mrd_m1   = 16'(T_MRD - 1);
  localparam logic [15:0] c_t_rcd_m1   = 16'(T_RCD - 1);
  localparam logic [15:0] c_t_wr_m1    = 16'(T_WR - 1);
  localparam logic [15:0] c_ref_int_m1 = 16'(REF_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REFRESH, S_ACTIVE, S_WR_WAIT, S_RD_WAIT, S_RECOVER
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_tmr;
  logic        r_tmr_en;
  logic        r_ref_pending;
  logic        r_we;
  logic [1:0]  r_ba;
  logic [8:0]  r_col;
  logic [31:0] r_data;
  logic [3:0]  r_mask;
  logic [31:0] w_dq_src;
  logic        w_tmr_expire;

`ifdef SDRAM_CTRL_DQ_INREG_EN
  localparam logic [15:0] c_rd_cap = 16'(CAS_LAT);
  logic [31:0] r_dq_in;
  always_ff @(posedge clk) begin
    if (!rst) r_dq_in <= '0;
    else      r_dq_in <= sdram_dq_i;
  end
  assign w_dq_src = r_dq_in;
`else
  localparam logic [15:0] c_rd_cap = 16'(CAS_LAT - 1);
  assign w_dq_src = sdram_dq_i;
`endif
  localparam logic [15:0] c_rd_fin = c_rd_cap + 16'd1;

  assign w_tmr_expire = r_tmr_en && (r_tmr == c_ref_int_m1);
  assign refresh      = r_ref_pending || (r_state == S_REFRESH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_INIT_WAIT;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_tmr_en      <= 1'b0;
      r_ref_pending <= 1'b0;
      r_we          <= 1'b0;
      r_ba          <= '0;
      r_col         <= '0;
      r_data        <= '0;
      r_mask        <= '0;
      rd_data       <= '0;
      finish        <= 1'b0;
      busy          <= 1'b1;
      sdram_cke     <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= 4'b1111;
      sdram_ba      <= '0;
      sdram_a       <= '0;
      sdram_dqm     <= 4'hF;
      sdram_dq_o    <= '0;
      sdram_dq_oe   <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_nop;
      finish    <= 1'b0;

      case (r_state)
        S_INIT_WAIT: begin
          if (r_cnt == c_t_init) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_pre;
            sdram_a <= 13'h0400;
            r_cnt   <= '0;
            r_state <= S_INIT_PRE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_INIT_PRE: begin
          if (r_cnt == c_t_rp_m1) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_ref;
            r_cnt   <= '0;
            r_state <= S_INIT_REF1;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_INIT_REF1: begin
          if (r_cnt == c_t_rfc_m1) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_ref;
            r_cnt   <= '0;
            r_state <= S_INIT_REF2;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_INIT_REF2: begin
          if (r_cnt == c_t_rfc_m1) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_mrs;
            sdram_a  <= c_mode;
            sdram_ba <= 2'b00;
            r_cnt    <= '0;
            r_state  <= S_INIT_MRS;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_INIT_MRS: begin
          if (r_cnt == c_t_mrd_m1) begin
            busy     <= 1'b0;
            r_tmr    <= '0;
            r_tmr_en <= 1'b1;
            r_state  <= S_IDLE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_IDLE: begin
          r_cnt <= '0;
          if (r_ref_pending) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_ref;
            busy    <= 1'b1;
            r_state <= S_REFRESH;
          end else if (acc) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_act;
            sdram_a  <= row_addr;
            sdram_ba <= ba;
            r_we     <= we;
            r_ba     <= ba;
            r_col    <= col_addr;
            r_data   <= data;
            r_mask   <= mask;
            busy     <= 1'b1;
            r_state  <= S_ACTIVE;
          end else busy <= w_tmr_expire;
        end
        // The IDLE cycle that follows is the last cycle of tRFC, so the exit
        // comes one count early to keep REF-to-next-command at T_RFC.
        S_REFRESH: begin
          if (r_cnt == c_t_rfc_m2) begin
            r_ref_pending <= 1'b0;
            busy          <= w_tmr_expire;
            r_state       <= S_IDLE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_ACTIVE: begin
          if (r_cnt == c_t_rcd_m1) begin
            sdram_a  <= {2'b00, 1'b1, 1'b0, r_col};
            sdram_ba <= r_ba;
            r_cnt    <= '0;
            if (r_we) begin
              {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_write;
              sdram_dq_o  <= r_data;
              sdram_dq_oe <= 1'b1;
              sdram_dqm   <= r_mask;
              r_state     <= S_WR_WAIT;
            end else begin
              {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_cmd_read;
              sdram_dqm <= 4'h0;
              r_state   <= S_RD_WAIT;
            end
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_WR_WAIT: begin
          sdram_dq_oe <= 1'b0;
          sdram_dqm   <= 4'hF;
          if (r_cnt == c_t_wr_m1) begin
            finish  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RECOVER;
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_RD_WAIT: begin
          if (r_cnt == c_rd_fin) begin
            finish    <= 1'b1;
            sdram_dqm <= 4'hF;
            r_cnt     <= '0;
            r_state   <= S_RECOVER;
          end else begin
            if (r_cnt == c_rd_cap) rd_data <= w_dq_src;
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RECOVER: begin
          if (r_cnt == c_t_rp_m1) begin
            busy    <= r_ref_pending || w_tmr_expire;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        default: r_state <= S_INIT_WAIT;
      endcase

      // Placed after the FSM so a new expiry wins over the REFRESH clear.
      if (r_tmr_en) begin
        if (w_tmr_expire) begin
          r_tmr         <= '0;
          r_ref_pending <= 1'b1;
        end else r_tmr <= r_tmr + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_ctrl_cmd.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_ctrl_cmd
// Brief   : Directed table-driven bench for sdram_ctrl_cmd (T_INIT=10,
//           REF_INTERVAL=100) with a one-word SDRAM read responder.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_ctrl_cmd;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                         WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001,
                         MRS = 4'b0000;
`ifdef SDRAM_CTRL_DQ_INREG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc = 1'b0, we = 1'b0;
  logic [1:0]  ba = '0;
  logic [12:0] row_addr = '0;
  logic [8:0]  col_addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rd_data;
  logic        finish, busy, refresh, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [3:0]  sdram_dqm;
  logic [31:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic [31:0] sdram_dq_i = 32'hBAD0_BAD0;
  logic [3:0]  cmd;
  logic        rd_seen = 1'b0;
  int          cyc = 0;
  int          n_checks = 0, n_fail = 0;

  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  sdram_ctrl_cmd #(.T_INIT(10), .REF_INTERVAL(100)) dut (
    .clk(clk), .rst(rst), .acc(acc), .we(we), .ba(ba), .row_addr(row_addr),
    .col_addr(col_addr), .data(data), .mask(mask), .rd_data(rd_data),
    .finish(finish), .busy(busy), .refresh(refresh), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_a(sdram_a), .sdram_dqm(sdram_dqm), .sdram_dq_o(sdram_dq_o),
    .sdram_dq_oe(sdram_dq_oe), .sdram_dq_i(sdram_dq_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CL=2 responder: data is on the bus for the cycle after a READ only.
  always @(negedge clk) begin
    sdram_dq_i = rd_seen ? 32'h1234_5678 : 32'hBAD0_BAD0;
    rd_seen    = (cmd == RD);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        acc, we;
    logic [3:0]  cmd;
    logic        busy, fin, oe;
    logic [3:0]  dqm;
    logic        chk_addr;
    logic [12:0] a;
    logic [1:0]  bank;
    logic [31:0] dq;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void add(string nm, logic a_, logic w_, logic [3:0] c_,
                              logic b_, logic f_, logic oe_, logic [3:0] m_);
    vec_t t;
    t.name = nm; t.acc = a_; t.we = w_; t.cmd = c_; t.busy = b_; t.fin = f_;
    t.oe = oe_; t.dqm = m_; t.chk_addr = 1'b0; t.a = '0; t.bank = '0;
    t.dq = '0; t.chk_rd = 1'b0; t.rd = '0;
    tbl.push_back(t);
  endfunction

  function automatic void set_addr(logic [12:0] a_, logic [1:0] b_, logic [31:0] d_);
    tbl[tbl.size()-1].chk_addr = 1'b1;
    tbl[tbl.size()-1].a = a_;
    tbl[tbl.size()-1].bank = b_;
    tbl[tbl.size()-1].dq = d_;
  endfunction

  function automatic void set_rd(logic [31:0] r_);
    tbl[tbl.size()-1].chk_rd = 1'b1;
    tbl[tbl.size()-1].rd = r_;
  endfunction

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      acc = tbl[i].acc;
      we  = tbl[i].we;
      @(negedge clk);
      check($sformatf("%s_ctl", tbl[i].name),
            64'({cmd, busy, finish, sdram_dq_oe, sdram_dqm}),
            64'({tbl[i].cmd, tbl[i].busy, tbl[i].fin, tbl[i].oe, tbl[i].dqm}));
      if (tbl[i].chk_addr)
        check($sformatf("%s_addr", tbl[i].name), 64'({sdram_a, sdram_ba}),
              64'({tbl[i].a, tbl[i].bank}));
      if (tbl[i].oe)
        check($sformatf("%s_dq", tbl[i].name), 64'(sdram_dq_o), 64'(tbl[i].dq));
      if (tbl[i].chk_rd)
        check($sformatf("%s_rd", tbl[i].name), 64'(rd_data), 64'(tbl[i].rd));
    end
    tbl.delete();
  endtask

  task automatic next_cmd(output int gap);
    gap = 0;
    do begin @(negedge clk); gap++; end while (cmd == NOP && gap < 64);
  endtask

  // Call right after rst is released; returns at the first non-NOP cycle.
  task automatic count_init_nops(output int nops, output int fins);
    nops = 0; fins = 0;
    @(negedge clk);
    check("init_cke", 64'(sdram_cke), 64'(1));
    while (cmd == NOP && nops < 64) begin
      nops++;
      if (finish) fins++;
      @(negedge clk);
    end
  endtask

  int gap, nops, fins, f_cyc, waited;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pins", 64'({sdram_cke, cmd, sdram_a, sdram_ba, sdram_dqm, sdram_dq_oe}),
          64'({1'b0, 4'b1111, 13'h0, 2'b00, 4'hF, 1'b0}));
    check("reset_dq_o", 64'(sdram_dq_o), 64'(0));
    check("reset_status", 64'({rd_data, finish, busy, refresh}),
          64'({32'h0, 1'b0, 1'b1, 1'b0}));

    // ---------------- power-up init ----------------
    rst = 1'b1;
    count_init_nops(nops, fins);
    check("init_nop_count", 64'(nops), 64'(10));
    check("init_pre", 64'({cmd, sdram_a[10], busy}), 64'({PRE, 1'b1, 1'b1}));
    next_cmd(gap);
    check("init_ref1", 64'({cmd, gap}), 64'({REF, 32'd2}));
    next_cmd(gap);
    check("init_ref2", 64'({cmd, gap}), 64'({REF, 32'd7}));
    next_cmd(gap);
    check("init_mrs", 64'({cmd, gap}), 64'({MRS, 32'd7}));
    check("init_mrs_addr", 64'({sdram_a, sdram_ba, busy}), 64'({13'h020, 2'b00, 1'b1}));
    @(negedge clk);
    check("init_busy_mrd1", 64'(busy), 64'(1));
    @(negedge clk);
    check("init_busy_fall", 64'({busy, refresh}), 64'({1'b0, 1'b0}));
    f_cyc = cyc;

    // ---------------- write ----------------
    ba = 2'd2; row_addr = 13'h155; col_addr = 9'h0AA; data = 32'hDEAD_BEEF; mask = 4'b0010;
    add("wr_act",  1, 1, ACT, 1, 0, 0, 4'hF); set_addr(13'h155, 2'd2, 32'h0);
    add("wr_trcd", 1, 1, NOP, 1, 0, 0, 4'hF);
    add("wr_cmd",  1, 1, WR,  1, 0, 1, 4'b0010); set_addr(13'h4AA, 2'd2, 32'hDEAD_BEEF);
    add("wr_twr",  1, 1, NOP, 1, 0, 0, 4'hF);
    add("wr_fin",  1, 1, NOP, 1, 1, 0, 4'hF);
    add("wr_rec",  0, 1, NOP, 1, 0, 0, 4'hF);
    add("wr_idle", 0, 0, NOP, 0, 0, 0, 4'hF);
    run_table();

    // ---------------- read ----------------
    ba = 2'd1; row_addr = 13'h0F0; col_addr = 9'h033; data = 32'h0; mask = 4'h0;
    add("rd_act",  1, 0, ACT, 1, 0, 0, 4'hF); set_addr(13'h0F0, 2'd1, 32'h0);
    add("rd_trcd", 1, 0, NOP, 1, 0, 0, 4'hF);
    add("rd_cmd",  1, 0, RD,  1, 0, 0, 4'h0); set_addr(13'h433, 2'd1, 32'h0);
    add("rd_cl1",  1, 0, NOP, 1, 0, 0, 4'h0); set_rd(32'h0);
    add("rd_cl2",  1, 0, NOP, 1, 0, 0, 4'h0);
    if (XL == 1) add("rd_inreg", 1, 0, NOP, 1, 0, 0, 4'h0);
    add("rd_fin",  1, 0, NOP, 1, 1, 0, 4'hF); set_rd(32'h1234_5678);
    add("rd_rec",  0, 0, NOP, 1, 0, 0, 4'hF);
    add("rd_idle", 0, 0, NOP, 0, 0, 0, 4'hF); set_rd(32'h1234_5678);
    run_table();

    // ---------------- refresh collision ----------------
    while (cyc < f_cyc + 99) @(negedge clk);
    check("ref_before", 64'({refresh, busy}), 64'({1'b0, 1'b0}));
    @(negedge clk);
    check("ref_pending_set", 64'({refresh, busy, cmd}), 64'({1'b1, 1'b1, NOP}));
    acc = 1'b1; we = 1'b1; ba = 2'd3; row_addr = 13'h0AB; col_addr = 9'h1FF;
    data = 32'hCAFE_F00D; mask = 4'h0;
    @(negedge clk);
    check("ref_cmd_first", 64'({cmd, refresh, busy}), 64'({REF, 1'b1, 1'b1}));
    repeat (5) @(negedge clk);
    check("ref_hold", 64'({cmd, refresh}), 64'({NOP, 1'b1}));
    @(negedge clk);
    check("ref_done", 64'({refresh, busy}), 64'({1'b0, 1'b0}));
    @(negedge clk);
    check("ref_then_act", 64'({cmd, sdram_a, sdram_ba}), 64'({ACT, 13'h0AB, 2'd3}));
    repeat (2) @(negedge clk);
    check("ref_wr_cmd", 64'({cmd, sdram_a, sdram_dq_oe, sdram_dqm}),
          64'({WR, 13'h5FF, 1'b1, 4'h0}));
    check("ref_wr_dq", 64'(sdram_dq_o), 64'(32'hCAFE_F00D));
    repeat (2) @(negedge clk);
    check("ref_wr_fin", 64'(finish), 64'(1));
    acc = 1'b0;

    // ---------------- reset mid-access ----------------
    waited = 0;
    while (busy && waited < 20) begin @(negedge clk); waited++; end
    check("rst_pre_idle", 64'(busy), 64'(0));
    acc = 1'b1; we = 1'b0; ba = 2'd0; row_addr = 13'h001; col_addr = 9'h002;
    @(negedge clk);
    check("rst_act", 64'(cmd), 64'(ACT));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort", 64'({sdram_cke, sdram_cs_n, busy, finish}),
          64'({1'b0, 1'b1, 1'b1, 1'b0}));
    acc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_init_nops(nops, fins);
    check("rst_reinit_nops", 64'(nops), 64'(10));
    check("rst_reinit_pre", 64'({cmd, sdram_a[10]}), 64'({PRE, 1'b1}));
    check("rst_no_finish", 64'(fins), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
